demux1x2_deser: RTL and testbench
=================================

# demux1x2_deser

Registered 1-to-2 time demultiplexer (2:1 deserializer) with valid/ready handshakes on both sides. It accepts a stream of DATA_WIDTH-bit words and steers them alternately into lane 0 and lane 1. Each completed pair is presented together on `y0`/`y1`. It is the inverse of the lane-select muxing used in the datapath, and it sits between the serialized operand stream and the dual-operand pipeline inputs.

## Interface

Parameters:
- `DATA_WIDTH`, default 8, width of each input word and of each output lane.

Ports:
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `in_valid` input 1: an input word is present on `in_data`.
- `in_ready` output 1: the block can accept a word this cycle.
- `in_data` input DATA_WIDTH: input word.
- `flush` input 1: close the current pair after any word accepted this cycle.
- `out_valid` output 1: a pair is held on `y0`/`y1`.
- `out_ready` input 1: the downstream stage accepts the pair this cycle.
- `y0` output DATA_WIDTH: lane 0, the first word of the pair.
- `y1` output DATA_WIDTH: lane 1, the second word of the pair. It is 0 for an odd (flushed) pair.
- `out_odd` output 1: the current pair holds only one word (lane 0).
- `pair_count` output 16: number of pairs transferred. Present only with `DEMUX_COUNT_EN`.

## Operation

- Handshake terms:
  - Input handshake: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
- The FSM has three states:
  - EMPTY: no word held.
  - HALF: lane 0 word held in an internal `hold` register.
  - FULL: pair on outputs, `out_valid`=1.
- `in_ready` = (state != FULL) || `out_ready`. This is a combinational path from `out_ready`.
- EMPTY:
  - Input handshake with `flush`=0: `hold`<=`in_data`, go to HALF.
  - Input handshake with `flush`=1: `y0`<=`in_data`, `y1`<=0, `out_odd`<=1, go to FULL.
  - `flush` with no handshake: ignored.
- HALF:
  - Input handshake: `y0`<=`hold`, `y1`<=`in_data`, `out_odd`<=0, go to FULL. A simultaneous `flush` is redundant and ignored.
  - `flush` with no handshake: `y0`<=`hold`, `y1`<=0, `out_odd`<=1, go to FULL.
- FULL:
  - No transfer: `y0`, `y1` and `out_odd` are held stable. `in_ready`=0 and `flush` is ignored.
  - Transfer with no input handshake: go to EMPTY.
  - Transfer with an input handshake: the accepted word is handled as in EMPTY, going to HALF, or to FULL/odd if `flush`=1.
- After a transfer with no new pair, `y0`/`y1`/`out_odd` keep their last values while `out_valid`=0.
- The block never drops or reorders words.

## Timing

- Reset, asynchronous on `rst_n` low:
  - State goes to EMPTY.
  - `hold`, `y0`, `y1` = 0; `out_odd`=0; `out_valid`=0; `pair_count`=0.
  - `in_ready` reads 1, but no word is accepted while `rst_n` is low.
- Reset mid-operation discards any held word and any pending pair. The first word after release is lane 0.
- Latency: the pair becomes visible (`out_valid`=1) on the cycle after the second word's handshake, or after the flush cycle.
- Throughput: one word per cycle sustained with `out_ready` tied high, giving one pair every 2 cycles.
- Backpressure: when `out_ready` is low in FULL, `in_ready` drops in the same cycle.
- `pair_count` increments on each output transfer, odd pairs included, and wraps from 0xFFFF to 0x0000.

## Configuration

- `DEMUX_COUNT_EN` defined:
  - The `pair_count` port and its 16-bit counter are compiled in, with behaviour as in Timing.
- Not defined:
  - The port and counter are absent and all other behaviour is identical.

## Test plan

- Reset: drive `rst_n` low mid-HALF with `hold`=0x3C -> `out_valid`=0, `y0`=`y1`=0. After release, send 0x11 and 0x22 -> `y0`=0x11, `y1`=0x22.
- Streaming: `out_ready`=1, words 0x01..0x06 back-to-back -> pairs (01,02), (03,04), (05,06). `out_valid` is high every second cycle, `in_ready` is constantly 1, `out_odd`=0.
- Backpressure: pair (0xA5,0x5A) valid, `out_ready`=0 for 3 cycles -> outputs stable and `in_ready`=0. Release with 0x77 offered -> transfer and 0x77 taken in the same cycle.
- Flush: send 0x9F, then `flush` alone -> `y0`=0x9F, `y1`=0, `out_odd`=1. `flush` in EMPTY or FULL -> no change.
- Simultaneous: `flush` with the second word (0x10,0x20) -> normal pair, `out_odd`=0. `flush` with a word in EMPTY -> odd pair, `y0`=that word.
- Counter (`DEMUX_COUNT_EN`): preload via 65535 transfers, one more -> `pair_count`=0.

Source files
------------

// File: rtl/demux1x2_deser_if.sv
// Handshake bundle for demux1x2_deser: serial word input side and paired output side.
interface demux1x2_deser_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] y0;
    logic [DATA_WIDTH-1:0] y1;
    logic                  out_odd;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, y0, y1, out_odd
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, y0, y1, out_odd
    );
endinterface

// File: rtl/demux1x2_deser.sv
// 2:1 deserializer: steers alternate words into lanes y0/y1 and presents them as a pair.
// Define DEMUX_COUNT_EN to add the 16-bit wrapping pair_count output.
module demux1x2_deser #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1x2_deser_if.slave   bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]       pair_count
`endif
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] y0_q;
    logic [DATA_WIDTH-1:0] y1_q;
    logic                  odd_q;
    logic                  valid_q;
    logic                  in_ready_c;
    logic                  accept;
    logic                  xfer;

    always_comb begin
        in_ready_c = (state != FULL) || bus.out_ready;
        accept     = bus.in_valid && in_ready_c;
        xfer       = valid_q && bus.out_ready;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.out_odd   = odd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            hold    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            odd_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (state == HALF) begin
            if (accept) begin
                y0_q    <= hold;
                y1_q    <= bus.in_data;
                odd_q   <= 1'b0;
                valid_q <= 1'b1;
                state   <= FULL;
            end else if (bus.flush) begin
                y0_q    <= hold;
                y1_q    <= '0;
                odd_q   <= 1'b1;
                valid_q <= 1'b1;
                state   <= FULL;
            end
        end else if (state != FULL || xfer) begin
            // FULL with a transfer frees the slot, so it loads exactly like EMPTY
            if (accept) begin
                if (bus.flush) begin
                    y0_q    <= bus.in_data;
                    y1_q    <= '0;
                    odd_q   <= 1'b1;
                    valid_q <= 1'b1;
                    state   <= FULL;
                end else begin
                    hold    <= bus.in_data;
                    valid_q <= 1'b0;
                    state   <= HALF;
                end
            end else begin
                valid_q <= 1'b0;
                state   <= EMPTY;
            end
        end
    end

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_count <= '0;
        end else if (xfer) begin
            pair_count <= pair_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux1x2_deser.sv
// Scoreboard bench for demux1x2_deser; the counter section runs only with DEMUX_COUNT_EN.
module tb_demux1x2_deser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct packed {
        logic [7:0] y0;
        logic [7:0] y1;
        logic       odd;
    } pair_t;

    pair_t      q[$];
    logic       m_half = 1'b0;
    logic [7:0] m_hold = '0;
    logic [15:0] m_count = '0;

    demux1x2_deser_if #(.DATA_WIDTH(8)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [15:0] pair_count;
`endif

    demux1x2_deser #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef DEMUX_COUNT_EN
        ,
        .pair_count (pair_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words in, expected pairs queued, popped on each modelled transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_half  = 1'b0;
            m_count = '0;
        end else begin
            logic  full_m;
            logic  acc_m;
            pair_t e;
            full_m = (q.size() != 0);
            acc_m  = bus.in_valid && (!full_m || bus.out_ready);
            check("out_valid", 32'(bus.out_valid), 32'(full_m));
            check("in_ready", 32'(bus.in_ready), 32'(!full_m || bus.out_ready));
`ifdef DEMUX_COUNT_EN
            check("pair_count", 32'(pair_count), 32'(m_count));
`endif
            if (full_m && bus.out_ready) begin
                e = q.pop_front();
                check("pair_y0", 32'(bus.y0), 32'(e.y0));
                check("pair_y1", 32'(bus.y1), 32'(e.y1));
                check("pair_odd", 32'(bus.out_odd), 32'(e.odd));
                m_count = m_count + 16'd1;
            end
            if (acc_m) begin
                if (m_half) begin
                    q.push_back('{y0: m_hold, y1: bus.in_data, odd: 1'b0});
                    m_half = 1'b0;
                end else if (bus.flush) begin
                    q.push_back('{y0: bus.in_data, y1: 8'h00, odd: 1'b1});
                end else begin
                    m_half = 1'b1;
                    m_hold = bus.in_data;
                end
            end else if (bus.flush && m_half) begin
                q.push_back('{y0: m_hold, y1: 8'h00, odd: 1'b1});
                m_half = 1'b0;
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] a,
                             input logic [7:0] b, input logic odd);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_y0"}, 32'(bus.y0), 32'(a));
        check({tag, "_y1"}, 32'(bus.y1), 32'(b));
        check({tag, "_odd"}, 32'(bus.out_odd), 32'(odd));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 8'h00, 1'b0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 1);

        // Streaming pairs with out_ready held high
        for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 0, 1);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);

        // Backpressure: 0x77 offered but refused until out_ready returns
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h5A, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'h77, 0, 0);
            check_out("bp_hold", 1'b1, 8'hA5, 8'h5A, 1'b0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        cyc(1, 8'h77, 0, 1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        cyc(1, 8'h78, 0, 1);
        check_out("bp_next", 1'b1, 8'h77, 8'h78, 1'b0);
        cyc(0, 8'h00, 0, 1);

        // Flush alone in HALF, then ignored in FULL and EMPTY
        cyc(1, 8'h9F, 0, 0);
        cyc(0, 8'h00, 1, 0);
        check_out("flush_half", 1'b1, 8'h9F, 8'h00, 1'b1);
        cyc(0, 8'h00, 1, 0);
        check_out("flush_full", 1'b1, 8'h9F, 8'h00, 1'b1);
        cyc(0, 8'h00, 0, 1);
        check_out("flush_drain", 1'b0, 8'h9F, 8'h00, 1'b1);
        cyc(0, 8'h00, 1, 1);
        check_out("flush_empty", 1'b0, 8'h9F, 8'h00, 1'b1);

        // Flush together with a word
        cyc(1, 8'h10, 0, 1);
        cyc(1, 8'h20, 1, 1);
        check_out("sim_pair", 1'b1, 8'h10, 8'h20, 1'b0);
        cyc(1, 8'h33, 1, 1);
        check_out("sim_full_odd", 1'b1, 8'h33, 8'h00, 1'b1);
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h44, 1, 0);
        check_out("sim_empty_odd", 1'b1, 8'h44, 8'h00, 1'b1);
        cyc(0, 8'h00, 0, 1);

        // Asynchronous reset with 0x3C held in lane 0
        cyc(1, 8'h3C, 0, 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_out("rst_mid", 1'b0, 8'h00, 8'h00, 1'b0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        check_out("rst_after", 1'b1, 8'h11, 8'h22, 1'b0);
        cyc(0, 8'h00, 0, 1);

`ifdef DEMUX_COUNT_EN
        rst_n = 1'b0;
        #2;
        check("cnt_reset", 32'(pair_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Each flushed word makes one odd pair per cycle once the first one is loaded
        for (int i = 0; i < 65536; i++) cyc(1, 8'(i), 1, 1);
        check("cnt_ffff", 32'(pair_count), 32'h0000FFFF);
        cyc(1, 8'h00, 1, 1);
        check("cnt_wrap", 32'(pair_count), 32'd0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
`endif

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
